// File: rtl/lc3b_fetch_stage.sv
// LC-3b instruction fetch stage: drives the instruction memory read port,
// owns the IF/ID pipeline register, and absorbs decode back-pressure with a
// one-entry skid buffer. Redirects flush the slot; a redirect that arrives
// while a read is still outstanding is parked until that read completes.
module lc3b_fetch_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic        imem_read,
   output logic [15:0] imem_address,
   input  logic [15:0] imem_rdata,
   input  logic        imem_resp,
   output logic        if_valid,
   output logic [15:0] if_pc,
   output logic [15:0] if_pc_plus2,
   output logic [15:0] if_ir,
   output logic [3:0]  if_opcode
);

   localparam int unsigned W    = 16;
   localparam int unsigned OP_W = 4;

   typedef enum logic [1:0] {
      S_FETCH   = 2'd0,
      S_HOLD    = 2'd1,
      S_DISCARD = 2'd2
   } state_e;

   state_e       state_q, state_d;
   logic [W-1:0] fetch_addr_q, fetch_addr_d;
   logic [W-1:0] pending_pc_q, pending_pc_d;
   logic [W-1:0] skid_pc_q, skid_pc_d;
   logic [W-1:0] skid_ir_q, skid_ir_d;
   logic         if_valid_q, if_valid_d;
   logic [W-1:0] if_pc_q, if_pc_d;
   logic [W-1:0] if_ir_q, if_ir_d;
   logic         slot_free;
   logic [W-1:0] redirect_aligned;

   // Fetch addresses are always halfword aligned.
   assign redirect_aligned = {redirect_pc[W-1:1], 1'b0};
   assign slot_free        = ~if_valid_q | ~stall;

   // Next-state logic for the fetch FSM, IF/ID slot and skid entry.
   always_comb begin
      state_d      = state_q;
      fetch_addr_d = fetch_addr_q;
      pending_pc_d = pending_pc_q;
      skid_pc_d    = skid_pc_q;
      skid_ir_d    = skid_ir_q;
      if_valid_d   = if_valid_q;
      if_pc_d      = if_pc_q;
      if_ir_d      = if_ir_q;

      // Slot drains when decode consumes it or a redirect flushes it;
      // any load below re-asserts valid.
      if (!stall || redirect) begin
         if_valid_d = 1'b0;
      end

      unique case (state_q)
         S_FETCH: begin
            if (imem_resp) begin
               if (redirect) begin
                  fetch_addr_d = redirect_aligned;
               end else if (slot_free) begin
                  if_valid_d   = 1'b1;
                  if_pc_d      = fetch_addr_q;
                  if_ir_d      = imem_rdata;
                  fetch_addr_d = fetch_addr_q + W'(2);
               end else begin
                  skid_pc_d = fetch_addr_q;
                  skid_ir_d = imem_rdata;
                  state_d   = S_HOLD;
               end
            end else if (redirect) begin
               pending_pc_d = redirect_aligned;
               state_d      = S_DISCARD;
            end
         end
         S_HOLD: begin
            if (redirect) begin
               fetch_addr_d = redirect_aligned;
               state_d      = S_FETCH;
            end else if (!stall) begin
               if_valid_d   = 1'b1;
               if_pc_d      = skid_pc_q;
               if_ir_d      = skid_ir_q;
               fetch_addr_d = skid_pc_q + W'(2);
               state_d      = S_FETCH;
            end
         end
         S_DISCARD: begin
            if (imem_resp) begin
               fetch_addr_d = redirect ? redirect_aligned : pending_pc_q;
               state_d      = S_FETCH;
            end else if (redirect) begin
               pending_pc_d = redirect_aligned;
            end
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   // State registers with synchronous reset; reset wins over any response.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_FETCH;
         fetch_addr_q <= '0;
         pending_pc_q <= '0;
         skid_pc_q    <= '0;
         skid_ir_q    <= '0;
         if_valid_q   <= 1'b0;
         if_pc_q      <= '0;
         if_ir_q      <= '0;
      end else begin
         state_q      <= state_d;
         fetch_addr_q <= fetch_addr_d;
         pending_pc_q <= pending_pc_d;
         skid_pc_q    <= skid_pc_d;
         skid_ir_q    <= skid_ir_d;
         if_valid_q   <= if_valid_d;
         if_pc_q      <= if_pc_d;
         if_ir_q      <= if_ir_d;
      end
   end

   // Read request is suppressed while in reset so no access is issued then.
   assign imem_read    = ~reset & (state_q != S_HOLD);
   assign imem_address = fetch_addr_q;
   assign if_valid     = if_valid_q;
   assign if_pc        = if_pc_q;
   assign if_ir        = if_ir_q;
   assign if_pc_plus2  = if_pc_q + W'(2);
   assign if_opcode    = if_ir_q[W-1 -: OP_W];

endmodule

// File: tb/tb_lc3b_fetch_stage.sv
// Directed bench for lc3b_fetch_stage; each task drives one scenario and
// checks hand-computed expectations one cycle at a time.
module tb_lc3b_fetch_stage;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        imem_read;
   logic [15:0] imem_address;
   logic [15:0] imem_rdata;
   logic        imem_resp;
   logic        if_valid;
   logic [15:0] if_pc;
   logic [15:0] if_pc_plus2;
   logic [15:0] if_ir;
   logic [3:0]  if_opcode;

   int tests_run    = 0;
   int tests_failed = 0;

   lc3b_fetch_stage dut (
      .clk          (clk),
      .reset        (reset),
      .stall        (stall),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .imem_read    (imem_read),
      .imem_address (imem_address),
      .imem_rdata   (imem_rdata),
      .imem_resp    (imem_resp),
      .if_valid     (if_valid),
      .if_pc        (if_pc),
      .if_pc_plus2  (if_pc_plus2),
      .if_ir        (if_ir),
      .if_opcode    (if_opcode)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
      imem_rdata = 16'h0000; imem_resp = 1'b0;
      step(); step();
      tests_run++; if (imem_read !== 1'b0) begin tests_failed++; $display("FAIL reset_read: got %0h exp 0", imem_read); end
      tests_run++; if (if_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %0h exp 0", if_valid); end
      tests_run++; if (if_pc !== 16'h0000) begin tests_failed++; $display("FAIL reset_pc: got %h exp 0000", if_pc); end
      tests_run++; if (if_ir !== 16'h0000) begin tests_failed++; $display("FAIL reset_ir: got %h exp 0000", if_ir); end
      tests_run++; if (imem_address !== 16'h0000) begin tests_failed++; $display("FAIL reset_addr: got %h exp 0000", imem_address); end
      reset = 1'b0;
      #1;
      tests_run++; if (imem_read !== 1'b1) begin tests_failed++; $display("FAIL post_reset_read: got %0h exp 1", imem_read); end
   endtask

   task automatic test_fetch();
      imem_resp = 1'b1; imem_rdata = 16'h1234;
      step();
      tests_run++; if (if_valid !== 1'b1) begin tests_failed++; $display("FAIL fetch0_valid: got %0h exp 1", if_valid); end
      tests_run++; if (if_pc !== 16'h0000) begin tests_failed++; $display("FAIL fetch0_pc: got %h exp 0000", if_pc); end
      tests_run++; if (if_ir !== 16'h1234) begin tests_failed++; $display("FAIL fetch0_ir: got %h exp 1234", if_ir); end
      tests_run++; if (if_opcode !== 4'b0001) begin tests_failed++; $display("FAIL fetch0_opcode: got %h exp 1", if_opcode); end
      tests_run++; if (if_pc_plus2 !== 16'h0002) begin tests_failed++; $display("FAIL fetch0_pc2: got %h exp 0002", if_pc_plus2); end
      tests_run++; if (imem_address !== 16'h0002) begin tests_failed++; $display("FAIL fetch0_addr: got %h exp 0002", imem_address); end
      imem_rdata = 16'h5678;
      step();
      tests_run++; if (if_pc !== 16'h0002) begin tests_failed++; $display("FAIL fetch1_pc: got %h exp 0002", if_pc); end
      tests_run++; if (if_ir !== 16'h5678) begin tests_failed++; $display("FAIL fetch1_ir: got %h exp 5678", if_ir); end
      tests_run++; if (imem_address !== 16'h0004) begin tests_failed++; $display("FAIL fetch1_addr: got %h exp 0004", imem_address); end
   endtask

   task automatic test_stall();
      stall = 1'b1; imem_resp = 1'b1; imem_rdata = 16'hABCD;
      step();
      imem_resp = 1'b0; imem_rdata = 16'h0000;
      for (int c = 0; c < 3; c++) begin
         tests_run++; if (imem_read !== 1'b0) begin tests_failed++; $display("FAIL hold_read[%0d]: got %0h exp 0", c, imem_read); end
         tests_run++; if (if_valid !== 1'b1) begin tests_failed++; $display("FAIL hold_valid[%0d]: got %0h exp 1", c, if_valid); end
         tests_run++; if (if_pc !== 16'h0002) begin tests_failed++; $display("FAIL hold_pc[%0d]: got %h exp 0002", c, if_pc); end
         tests_run++; if (if_ir !== 16'h5678) begin tests_failed++; $display("FAIL hold_ir[%0d]: got %h exp 5678", c, if_ir); end
         if (c < 2) step();
      end
      stall = 1'b0;
      step();
      tests_run++; if (if_valid !== 1'b1) begin tests_failed++; $display("FAIL release_valid: got %0h exp 1", if_valid); end
      tests_run++; if (if_ir !== 16'hABCD) begin tests_failed++; $display("FAIL release_ir: got %h exp abcd", if_ir); end
      tests_run++; if (if_pc !== 16'h0004) begin tests_failed++; $display("FAIL release_pc: got %h exp 0004", if_pc); end
      tests_run++; if (imem_read !== 1'b1) begin tests_failed++; $display("FAIL release_read: got %0h exp 1", imem_read); end
      tests_run++; if (imem_address !== 16'h0006) begin tests_failed++; $display("FAIL release_addr: got %h exp 0006", imem_address); end
      step();
      tests_run++; if (if_valid !== 1'b0) begin tests_failed++; $display("FAIL drain_valid: got %0h exp 0", if_valid); end
   endtask

   task automatic test_redirect_discard();
      redirect = 1'b1; redirect_pc = 16'h3001;
      step();
      redirect = 1'b0;
      tests_run++; if (imem_read !== 1'b1) begin tests_failed++; $display("FAIL discard_read: got %0h exp 1", imem_read); end
      tests_run++; if (imem_address !== 16'h0006) begin tests_failed++; $display("FAIL discard_addr0: got %h exp 0006", imem_address); end
      tests_run++; if (if_valid !== 1'b0) begin tests_failed++; $display("FAIL discard_valid0: got %0h exp 0", if_valid); end
      step();
      tests_run++; if (imem_address !== 16'h0006) begin tests_failed++; $display("FAIL discard_addr1: got %h exp 0006", imem_address); end
      imem_resp = 1'b1; imem_rdata = 16'hDEAD;
      step();
      imem_resp = 1'b0;
      tests_run++; if (if_valid !== 1'b0) begin tests_failed++; $display("FAIL discard_drop: got %0h exp 0", if_valid); end
      tests_run++; if (imem_address !== 16'h3000) begin tests_failed++; $display("FAIL discard_newaddr: got %h exp 3000", imem_address); end
   endtask

   task automatic test_redirect_resp_stall();
      imem_resp = 1'b1; imem_rdata = 16'h1111;
      step();
      tests_run++; if (if_pc !== 16'h3000) begin tests_failed++; $display("FAIL rrs_pre_pc: got %h exp 3000", if_pc); end
      stall = 1'b1; redirect = 1'b1; redirect_pc = 16'h4000; imem_rdata = 16'h2222;
      step();
      stall = 1'b0; redirect = 1'b0; imem_resp = 1'b0;
      tests_run++; if (if_valid !== 1'b0) begin tests_failed++; $display("FAIL rrs_valid: got %0h exp 0", if_valid); end
      tests_run++; if (imem_read !== 1'b1) begin tests_failed++; $display("FAIL rrs_read: got %0h exp 1", imem_read); end
      tests_run++; if (imem_address !== 16'h4000) begin tests_failed++; $display("FAIL rrs_addr: got %h exp 4000", imem_address); end
   endtask

   task automatic test_wrap();
      redirect = 1'b1; redirect_pc = 16'hFFFF; imem_resp = 1'b1; imem_rdata = 16'h1357;
      step();
      redirect = 1'b0;
      tests_run++; if (imem_address !== 16'hFFFE) begin tests_failed++; $display("FAIL wrap_align: got %h exp fffe", imem_address); end
      imem_rdata = 16'h5AAA;
      step();
      imem_resp = 1'b0;
      tests_run++; if (if_pc !== 16'hFFFE) begin tests_failed++; $display("FAIL wrap_pc: got %h exp fffe", if_pc); end
      tests_run++; if (if_pc_plus2 !== 16'h0000) begin tests_failed++; $display("FAIL wrap_pc2: got %h exp 0000", if_pc_plus2); end
      tests_run++; if (if_opcode !== 4'h5) begin tests_failed++; $display("FAIL wrap_opcode: got %h exp 5", if_opcode); end
      tests_run++; if (imem_address !== 16'h0000) begin tests_failed++; $display("FAIL wrap_addr: got %h exp 0000", imem_address); end
   endtask

   task automatic test_reset_pending();
      imem_resp = 1'b1; imem_rdata = 16'h0F0F;
      step();
      tests_run++; if (imem_address !== 16'h0002) begin tests_failed++; $display("FAIL rp_pre_addr: got %h exp 0002", imem_address); end
      imem_resp = 1'b0;
      step();
      reset = 1'b1; imem_resp = 1'b1; imem_rdata = 16'h7777;
      #1;
      tests_run++; if (imem_read !== 1'b0) begin tests_failed++; $display("FAIL rp_read: got %0h exp 0", imem_read); end
      step();
      reset = 1'b0; imem_resp = 1'b0;
      #1;
      tests_run++; if (if_valid !== 1'b0) begin tests_failed++; $display("FAIL rp_valid: got %0h exp 0", if_valid); end
      tests_run++; if (if_ir !== 16'h0000) begin tests_failed++; $display("FAIL rp_ir: got %h exp 0000", if_ir); end
      tests_run++; if (imem_read !== 1'b1) begin tests_failed++; $display("FAIL rp_read_after: got %0h exp 1", imem_read); end
      tests_run++; if (imem_address !== 16'h0000) begin tests_failed++; $display("FAIL rp_addr: got %h exp 0000", imem_address); end
      step();
      tests_run++; if (if_valid !== 1'b0) begin tests_failed++; $display("FAIL rp_valid_after: got %0h exp 0", if_valid); end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_stall();
      test_redirect_discard();
      test_redirect_resp_stall();
      test_wrap();
      test_reset_pending();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/lc3b_fetch_stage.md
LC3B_FETCH_STAGE -- requirements
Module: lc3b_fetch_stage

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 The block SHALL have the following ports:
- clk  in  1  clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  decode stage cannot accept the IF/ID register this cycle
- redirect  in  1  taken branch/jump/trap from downstream; flush and refetch
- redirect_pc  in  16  new fetch address (lc3b_word)
- imem_read  out  1  instruction memory read request
- imem_address  out  16  instruction memory address
- imem_rdata  in  16  instruction word, valid only when imem_resp=1
- imem_resp  in  1  single-cycle completion of the outstanding read
- if_valid  out  1  IF/ID register holds a valid instruction
- if_pc  out  16  address of the held instruction
- if_pc_plus2  out  16  if_pc + 2, modulo 2^16
- if_ir  out  16  held instruction word
- if_opcode  out  4  if_ir[15:12] as lc3b_opcode

Function
REQ-003 The block SHALL implement three states: FETCH, HOLD and DISCARD.
REQ-004 State behaviour:
- FETCH: imem_read=1.
- DISCARD: imem_read=1.
- HOLD: imem_read=0.
REQ-005 The block SHALL drive imem_address from an internal fetch_addr register that never changes while imem_read=1 and imem_resp=0.
REQ-006 The block SHALL force bit 0 of every loaded address to 0, including redirect_pc and the reset vector.
REQ-007 The output slot SHALL be free when if_valid=0 or stall=0.
REQ-008 FETCH with imem_resp=1, redirect=0 and the slot free, on the same edge:
- if_ir<=imem_rdata
- if_pc<=fetch_addr
- if_valid<=1
- fetch_addr<=fetch_addr+2
- remain in FETCH
REQ-009 FETCH with imem_resp=1, redirect=0 and the slot not free:
- capture imem_rdata and fetch_addr into a one-entry skid register
- go to HOLD
REQ-010 HOLD with stall=0 and redirect=0:
- move the skid entry into the IF/ID register, with if_valid<=1
- fetch_addr<=skid pc+2
- go to FETCH
REQ-011 HOLD with stall=1 and redirect=0: all state SHALL be unchanged.
REQ-012 Redirect in FETCH with imem_resp=1, or in HOLD:
- drop the returned word or the skid entry
- fetch_addr<=redirect_pc
- go to FETCH
REQ-013 Redirect in FETCH with imem_resp=0:
- store redirect_pc in pending_pc
- go to DISCARD
REQ-014 DISCARD:
- keep the outstanding address stable
- when imem_resp=1, drop the data and set fetch_addr<=pending_pc (redirect_pc if redirect=1 that cycle), then go to FETCH
- a redirect while imem_resp=0 overwrites pending_pc
REQ-015 redirect=1 SHALL clear if_valid on the next edge regardless of stall; redirect has priority over stall and over any returning data.
REQ-016 When if_valid=1, stall=0 and no new instruction is loaded that edge, the block SHALL clear if_valid.
REQ-017 When stall=1 and redirect=0, the block SHALL hold if_valid, if_pc and if_ir unchanged.
REQ-018 The block SHALL compute address increments modulo 2^16 (0xFFFE+2 = 0x0000).
REQ-019 The block SHALL derive if_pc_plus2 and if_opcode combinationally from if_pc and if_ir.
REQ-020 Latency: an instruction SHALL appear at the IF/ID outputs on the edge that samples imem_resp=1, provided the slot is free.

Reset
REQ-021 On a clock edge with reset=1, the block SHALL set:
- state=FETCH
- fetch_addr=0x0000, pending_pc=0x0000
- if_valid=0, if_pc=0x0000, if_ir=0x0000
- skid register cleared
REQ-022 While reset=1, imem_read SHALL be 0, and an imem_resp arriving during reset SHALL be ignored.
REQ-023 Reset asserted mid-request SHALL abandon the request, and the first post-reset read SHALL be to 0x0000.

Verification
REQ-024 A bench SHALL cover these directed scenarios:
- Reset, then a memory with zero-wait resp returning 0x1234, 0x5678 -> if_pc 0x0000, 0x0002 on consecutive cycles, if_ir matching, if_opcode op_add for 0x1234.
- stall=1 held 3 cycles while resp returns 0xABCD at 0x0004 -> state HOLD, imem_read=0, if_* unchanged; on release if_ir=0xABCD, if_pc=0x0004, next fetch 0x0006.
- redirect=1 with redirect_pc=0x3001 and no resp outstanding completion -> DISCARD, address stable; old data dropped; next read to 0x3000, if_valid=0 meanwhile.
- redirect and imem_resp in the same cycle with stall=1 -> word dropped, if_valid=0 next cycle, next read to redirect_pc.
- fetch_addr 0xFFFE with resp -> if_pc=0xFFFE, if_pc_plus2=0x0000, next read to 0x0000.
- reset asserted while a read is pending, with resp on the reset cycle -> no output, imem_read=0 during reset, first read to 0x0000.
